// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/prod_accum_if.sv
// Frame control, product input and result bus of the product accumulator.
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             din_vld;
  logic [15:0]      din_u;
  logic [15:0]      din_s;
  logic             busy;
  logic [ACC_W-1:0] acc_u;
  logic [ACC_W-1:0] acc_s;
  logic             acc_vld;
  logic             ovf_u;
  logic             ovf_s;

  modport master (
    output start, len, din_vld, din_u, din_s,
    input  busy, acc_u, acc_s, acc_vld, ovf_u, ovf_s
  );

  modport slave (
    input  start, len, din_vld, din_u, din_s,
    output busy, acc_u, acc_s, acc_vld, ovf_u, ovf_s
  );

endinterface

// File: rtl/prod_accum_sat_add.sv
// Combinational saturating adder; is_signed selects two's-complement or
// unsigned limits, ovf flags that the true sum was clamped.
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  always_comb begin
    raw = is_signed ? ({a[W-1], a} + {b[W-1], b}) : ({1'b0, a} + {1'b0, b});
    sum = raw[W-1:0];
    ovf = 1'b0;
    if (is_signed) begin
      // Extended sign disagreeing with the result sign means the range was left.
      if (raw[W] != raw[W-1]) begin
        ovf = 1'b1;
        sum = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end else if (raw[W]) begin
      ovf = 1'b1;
      sum = '1;
    end
  end

endmodule

// File: rtl/prod_accum.sv
// Frame-based accumulator of unsigned and signed 16-bit products with
// per-frame saturation flags; inputs come straight from registered multiplier outputs.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  prod_accum_if.slave bus
);

  state_t           state_reg, state_next;
  logic             start_take, sample_take;
  logic [LEN_W-1:0] len_reg, cnt_reg;
  logic [ACC_W-1:0] acc_u_reg, acc_s_reg;
  logic             ovf_u_reg, ovf_s_reg, vld_reg;

  logic [ACC_W-1:0] lane_acc [2];
  logic             lane_sticky [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    start_take  = 1'b0;
    sample_take = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && bus.len != '0) begin
          start_take = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (bus.din_vld) begin
          sample_take = 1'b1;
          if (cnt_reg == len_reg - LEN_W'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane 0 accumulates din_u unsigned, lane 1 accumulates din_s signed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [ACC_W-1:0] acc_reg;
    logic             sticky_reg;
    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    if (gi == 0) begin : g_u
      assign operand = {{(ACC_W-16){1'b0}}, bus.din_u};
    end else begin : g_s
      assign operand = {{(ACC_W-16){bus.din_s[15]}}, bus.din_s};
    end

    sat_add #(.W(ACC_W)) u_sat_add (
      .a         (acc_reg),
      .b         (operand),
      .is_signed (gi == 1),
      .sum       (sum),
      .ovf       (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg    <= '0;
        sticky_reg <= 1'b0;
      end else if (start_take) begin
        acc_reg    <= '0;
        sticky_reg <= 1'b0;
      end else if (sample_take) begin
        acc_reg    <= sum;
        sticky_reg <= sticky_reg | ovf;
      end
    end

    assign lane_acc[gi]    = acc_reg;
    assign lane_sticky[gi] = sticky_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg   <= '0;
      cnt_reg   <= '0;
      acc_u_reg <= '0;
      acc_s_reg <= '0;
      ovf_u_reg <= 1'b0;
      ovf_s_reg <= 1'b0;
      vld_reg   <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      if (start_take) begin
        len_reg <= bus.len;
        cnt_reg <= '0;
      end else if (sample_take) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
      // Results are published only from DONE and otherwise hold.
      if (state_reg == DONE) begin
        acc_u_reg <= lane_acc[0];
        acc_s_reg <= lane_acc[1];
        ovf_u_reg <= lane_sticky[0];
        ovf_s_reg <= lane_sticky[1];
        vld_reg   <= 1'b1;
      end
    end
  end

  assign bus.busy    = (state_reg != IDLE);
  assign bus.acc_u   = acc_u_reg;
  assign bus.acc_s   = acc_s_reg;
  assign bus.ovf_u   = ovf_u_reg;
  assign bus.ovf_s   = ovf_s_reg;
  assign bus.acc_vld = vld_reg;

endmodule

// File: tb/tb_prod_accum.sv
// Drives one stimulus stream into a 24-bit and an 18-bit accumulator and
// scoreboards each against a saturating-arithmetic frame model.
module tb_prod_accum;

  typedef struct {
    longint u;
    longint s;
    bit     ou;
    bit     os;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        din_vld;
  logic [15:0] din_u;
  logic [15:0] din_s;

  int   vectors = 0;
  int   miscompares = 0;
  int   cur_u[$];
  int   cur_s[$];
  exp_t q24[$];
  exp_t q18[$];
  exp_t last24, last18;

  always #5 clk = ~clk;

  prod_accum_if #(.ACC_W(24), .LEN_W(8)) bus24 ();
  prod_accum_if #(.ACC_W(18), .LEN_W(8)) bus18 ();

  assign bus24.start = start;   assign bus18.start = start;
  assign bus24.len = len;       assign bus18.len = len;
  assign bus24.din_vld = din_vld; assign bus18.din_vld = din_vld;
  assign bus24.din_u = din_u;   assign bus18.din_u = din_u;
  assign bus24.din_s = din_s;   assign bus18.din_s = din_s;

  prod_accum #(.ACC_W(24), .LEN_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24));
  prod_accum #(.ACC_W(18), .LEN_W(8)) dut18 (.clk(clk), .rst_n(rst_n), .bus(bus18));

  function automatic void check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Frame result from the rules: add each sample, clamp to the range after every add.
  function automatic exp_t model(int w);
    longint umax;
    longint smax;
    longint smin;
    exp_t   e;
    umax = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    e.u = 0; e.s = 0; e.ou = 1'b0; e.os = 1'b0;
    foreach (cur_u[i]) begin
      e.u += cur_u[i];
      if (e.u > umax) begin e.u = umax; e.ou = 1'b1; end
      e.s += cur_s[i];
      if (e.s > smax) begin e.s = smax; e.os = 1'b1; end
      if (e.s < smin) begin e.s = smin; e.os = 1'b1; end
    end
    return e;
  endfunction

  task automatic fill_const(input int n, input int u, input int s);
    cur_u.delete(); cur_s.delete();
    for (int i = 0; i < n; i++) begin cur_u.push_back(u); cur_s.push_back(s); end
  endtask

  task automatic fill_rand(input int n);
    int r;
    cur_u.delete(); cur_s.delete();
    for (int i = 0; i < n; i++) begin
      cur_u.push_back(int'($urandom_range(0, 65535)));
      r = int'($urandom_range(0, 65535));
      cur_s.push_back(r >= 32768 ? r - 65536 : r);
    end
  endtask

  // Called at a negedge; returns at the negedge right after acc_vld is seen,
  // so a following call issues start in the cycle after DONE.
  task automatic frame(input int n, input int gap, input bit poke);
    int g;
    q24.push_back(model(24));
    q18.push_back(model(18));
    start = 1'b1; len = 8'(n);
    din_vld = 1'b1; din_u = 16'($urandom); din_s = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("busy24_after_start", longint'(bus24.busy), 1);
    check("busy18_after_start", longint'(bus18.busy), 1);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        din_vld = 1'b0; din_u = 16'($urandom); din_s = 16'($urandom);
        if (poke) begin start = 1'b1; len = 8'($urandom_range(0, 255)); end
        @(negedge clk);
        start = 1'b0;
      end
      din_vld = 1'b1; din_u = 16'(cur_u[i]); din_s = 16'(cur_s[i]);
      if (poke) begin start = 1'b1; len = 8'($urandom_range(0, 255)); end
      @(negedge clk);
      start = 1'b0;
    end
    din_vld = 1'b1; din_u = 16'($urandom); din_s = 16'($urandom);
    check("vld24_early", longint'(bus24.acc_vld), 0);
    check("busy24_in_done", longint'(bus24.busy), 1);
    @(negedge clk);
    check("vld24_latency", longint'(bus24.acc_vld), 1);
    check("vld18_latency", longint'(bus18.acc_vld), 1);
    check("busy24_after_done", longint'(bus24.busy), 0);
    din_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus24.acc_vld) begin
      if (q24.size() == 0) check("vld24_unexpected", 1, 0);
      else begin
        last24 = q24.pop_front();
        check("acc_u24", longint'(bus24.acc_u), last24.u);
        check("acc_s24", longint'($signed(bus24.acc_s)), last24.s);
        check("ovf_u24", longint'(bus24.ovf_u), longint'(last24.ou));
        check("ovf_s24", longint'(bus24.ovf_s), longint'(last24.os));
      end
    end
    if (rst_n === 1'b1 && bus18.acc_vld) begin
      if (q18.size() == 0) check("vld18_unexpected", 1, 0);
      else begin
        last18 = q18.pop_front();
        check("acc_u18", longint'(bus18.acc_u), last18.u);
        check("acc_s18", longint'($signed(bus18.acc_s)), last18.s);
        check("ovf_u18", longint'(bus18.ovf_u), longint'(last18.ou));
        check("ovf_s18", longint'(bus18.ovf_s), longint'(last18.os));
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, longint'(bus24.busy | bus18.busy), 0);
    check({tag, "_vld"}, longint'(bus24.acc_vld | bus18.acc_vld), 0);
    check({tag, "_acc_u24"}, longint'(bus24.acc_u), 0);
    check({tag, "_acc_s24"}, longint'(bus24.acc_s), 0);
    check({tag, "_acc_u18"}, longint'(bus18.acc_u), 0);
    check({tag, "_acc_s18"}, longint'(bus18.acc_s), 0);
    check({tag, "_ovf"}, longint'({bus24.ovf_u, bus24.ovf_s, bus18.ovf_u, bus18.ovf_s}), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; din_vld = 1'b0; din_u = '0; din_s = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // Signed/unsigned mix with one-cycle gaps; start issued on the first edge after reset.
    cur_u = '{100, 200, 300, 400};
    cur_s = '{-5, 10, -20, 7};
    frame(4, 1, 1'b0);

    fill_const(5, 65025, 0);       frame(5, 0, 1'b0);
    fill_const(9, 0, 16384);       frame(9, -1, 1'b0);
    fill_const(9, 0, -16256);      frame(9, -1, 1'b0);

    // Zero-length start must be ignored.
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy24", longint'(bus24.busy), 0);
    check("len0_busy18", longint'(bus18.busy), 0);
    repeat (3) @(negedge clk);

    // Starts arriving mid-frame must not disturb it.
    fill_rand(6); frame(6, 2, 1'b1);

    // Reset after two of four samples abandons the frame.
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_vld = 1'b1; din_u = 16'd1000; din_s = 16'd500;
      @(negedge clk);
    end
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_cleared("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_const(1, 7, 0); frame(1, 0, 1'b0);

    // Back-to-back frames.
    fill_const(1, 3, 0); frame(1, 0, 1'b0);
    cur_u = '{1, 2}; cur_s = '{0, 0}; frame(2, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      fill_rand(int'($urandom_range(1, 20)));
      frame(cur_u.size(), -1, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Idle with stray inputs: results must hold.
    din_vld = 1'b1; din_u = 16'hFFFF; start = 1'b1; len = 8'd0;
    repeat (6) @(negedge clk);
    din_vld = 1'b0; start = 1'b0;
    check("pending24", longint'(q24.size()), 0);
    check("pending18", longint'(q18.size()), 0);
    check("hold_acc_u24", longint'(bus24.acc_u), last24.u);
    check("hold_acc_s18", longint'($signed(bus18.acc_s)), last18.s);
    check("hold_ovf_s18", longint'(bus18.ovf_s), longint'(last18.os));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
